// File: rtl/alu_mc_pkg.sv
// Definitions: opcode mnemonics and controller states shared by the multi-cycle ALU
package Definitions;
  typedef enum logic [3:0] {
    kADD = 4'd0,
    kXOR = 4'd1,
    kORR = 4'd2,
    kBEQ = 4'd3,
    kBNE = 4'd4,
    kSLL = 4'd5,
    kSRL = 4'd6,
    kXXR = 4'd7,
    kSUB = 4'd8,
    kAND = 4'd9,
    kMUL = 4'd10,
    kSRA = 4'd11
  } op_mne;
  typedef enum logic [1:0] {IDLE, MUL, DONE} alu_state_e;
endpackage

// File: rtl/alu_mc_seq_mul.sv
// seq_mul: shift-add multiplier, one partial product per cycle over W cycles
module seq_mul #(
  parameter int W = 8
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           start,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);
  localparam int CW = $clog2(W);
  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] r_a;
  logic [W-1:0]   r_b;
  logic [CW-1:0]  r_cnt;
  logic           r_busy;
  logic [2*W-1:0] w_next;
  // product includes the partial term of the current iteration, so it is final while done is high
  assign w_next  = r_acc + (r_b[0] ? r_a : '0);
  assign product = w_next;
  assign busy    = r_busy;
  assign done    = r_busy && (r_cnt == CW'(W - 1));
  // load operands on start, then add one shifted multiplicand per cycle
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      r_acc  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start) begin
      r_acc  <= '0;
      r_a    <= {{W{1'b0}}, A};
      r_b    <= B;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_acc  <= w_next;
      r_a    <= r_a << 1;
      r_b    <= r_b >> 1;
      r_cnt  <= r_cnt + CW'(1);
      r_busy <= r_cnt != CW'(W - 1);
    end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: valid/ready multi-cycle ALU with registered result and status flags
module alu_mc
  import Definitions::*;
#(
  parameter int W   = 8,
  parameter int Ops = 4
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           InValid,
  output logic           InReady,
  input  logic [W-1:0]   InputA,
  input  logic [W-1:0]   InputB,
  input  logic [Ops-1:0] OP,
  output logic           OutValid,
  input  logic           OutReady,
  output logic [W-1:0]   Out,
  output logic           Jump,
  output logic           Zero,
  output logic           Parity,
  output logic           Carry,
  output logic           Illegal
);
  alu_state_e     r_state;
  logic [W-1:0]   r_out;
  logic           r_valid;
  logic           r_jump;
  logic           r_zero;
  logic           r_parity;
  logic           r_carry;
  logic           r_illegal;
  logic [W-1:0]   w_res;
  logic           w_carry;
  logic           w_jump;
  logic           w_illegal;
  logic           w_accept;
  logic           w_is_mul;
  logic           w_mul_busy;
  logic           w_mul_done;
  logic [2*W-1:0] w_prod;
`ifdef __ICARUS__
  op_mne w_op_mne;
  assign w_op_mne = op_mne'(OP);
`endif
  assign InReady  = !w_mul_busy && (r_state == IDLE || (r_state == DONE && OutReady));
  assign w_accept = InValid && InReady;
  assign w_is_mul = OP == Ops'(kMUL);
  assign Out      = r_out;
  assign OutValid = r_valid;
  assign Jump     = r_jump;
  assign Zero     = r_zero;
  assign Parity   = r_parity;
  assign Carry    = r_carry;
  assign Illegal  = r_illegal;
  seq_mul #(.W(W)) u_mul (
    .Clk     (Clk),
    .Reset   (Reset),
    .start   (w_accept && w_is_mul),
    .A       (InputA),
    .B       (InputB),
    .busy    (w_mul_busy),
    .done    (w_mul_done),
    .product (w_prod)
  );
  // single-cycle datapath; MUL result comes from seq_mul instead
  always_comb begin
    w_res     = '0;
    w_carry   = 1'b0;
    w_jump    = 1'b0;
    w_illegal = 1'b0;
    case (OP)
      Ops'(kADD): {w_carry, w_res} = {1'b0, InputA} + {1'b0, InputB};
      Ops'(kXOR): w_res = InputA ^ InputB;
      Ops'(kORR): w_res = InputA | InputB;
      Ops'(kBEQ): begin w_jump = InputA == InputB; w_res = {{(W-1){1'b0}}, w_jump}; end
      Ops'(kBNE): begin w_jump = InputA != InputB; w_res = {{(W-1){1'b0}}, w_jump}; end
      Ops'(kSLL): w_res = InputA << InputB;
      Ops'(kSRL): w_res = InputA >> InputB;
      Ops'(kXXR): w_res = {{(W-1){1'b0}}, ^{InputA, InputB}};
      Ops'(kSUB): {w_carry, w_res} = {1'b0, InputA} - {1'b0, InputB};
      Ops'(kAND): w_res = InputA & InputB;
      Ops'(kMUL): w_res = '0;
      Ops'(kSRA): w_res = $signed(InputA) >>> InputB;
      default:    w_illegal = 1'b1;
    endcase
  end
  // controller FSM; result and flags are loaded only when an operation completes
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      r_state   <= IDLE;
      r_out     <= '0;
      r_valid   <= 1'b0;
      r_jump    <= 1'b0;
      r_zero    <= 1'b0;
      r_parity  <= 1'b0;
      r_carry   <= 1'b0;
      r_illegal <= 1'b0;
    end else case (r_state)
      IDLE, DONE:
        if (w_accept && w_is_mul) begin
          r_state <= MUL;
          r_valid <= 1'b0;
        end else if (w_accept) begin
          r_state   <= DONE;
          r_valid   <= 1'b1;
          r_out     <= w_res;
          r_jump    <= w_jump;
          r_zero    <= ~|w_res;
          r_parity  <= ^w_res;
          r_carry   <= w_carry;
          r_illegal <= w_illegal;
        end else if (r_state == DONE && OutReady) begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      MUL:
        if (w_mul_done) begin
          r_state   <= DONE;
          r_valid   <= 1'b1;
          r_out     <= w_prod[W-1:0];
          r_jump    <= 1'b0;
          r_zero    <= ~|w_prod[W-1:0];
          r_parity  <= ^w_prod[W-1:0];
          r_carry   <= |w_prod[2*W-1:W];
          r_illegal <= 1'b0;
        end
      default: r_state <= IDLE;
    endcase
endmodule
